// File: rtl/cc_ingr_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cc_ingr_req_scheduler
// Brief    : Round-robin scheduler that shares the 64-bit ingress req stream
//            between CH_NUM requesters, bounded by in-flight credit tracked
//            from resp retirements. Optional request checking is enabled by
//            the CC_INGR_SCHED_ERR_EN macro.
// Revision : 1.0
// ============================================================================
module cc_ingr_req_scheduler #(
  parameter int          CH_NUM          = 4,
  parameter int          MAX_OUTSTANDING = 8,
  parameter logic [15:0] MAX_BURST       = 16'd4096
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [CH_NUM-1:0]     ch_req_valid,
  input  logic [16*CH_NUM-1:0]  ch_req_burst,
  input  logic [CH_NUM-1:0]     ch_req_sof,
  input  logic [CH_NUM-1:0]     ch_req_eof,
  output logic [CH_NUM-1:0]     ch_req_ready,
  output logic                  req_tvalid,
  input  logic                  req_tready,
  output logic [63:0]           req_tdata,
  input  logic                  resp_tvalid,
  input  logic                  resp_tready,
  input  logic [63:0]           resp_tdata,
  output logic [7:0]            outstanding,
  output logic [3:0]            sched_error,
  output logic                  sched_error_ap_vld
);

  localparam int         C_IDX_W   = $clog2(CH_NUM);
  localparam logic [7:0] C_MAX_OUT = 8'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [C_IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [7:0]           outstanding_q, outstanding_d;
  logic [63:0]          req_tdata_q, req_tdata_d;
  logic [CH_NUM-1:0]    ch_req_ready_q, ch_req_ready_d;
  logic [3:0]           sched_error_q, sched_error_d;
  logic                 sched_error_ap_vld_q, sched_error_ap_vld_d;

  logic [15:0]          w_burst [CH_NUM];
  logic [CH_NUM-1:0]    w_pending;
  logic [C_IDX_W-1:0]   w_scan;
  logic                 w_win_found;
  logic [C_IDX_W-1:0]   w_win_idx;
  logic [15:0]          w_win_burst;
  logic                 w_win_sof, w_win_eof;
  logic                 w_bad_zero, w_bad_big, w_win_bad;
  logic                 w_issue, w_retire, w_underflow;
  logic                 w_take, w_load;
  logic                 w_unused;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_burst
    assign w_burst[g] = ch_req_burst[16*g +: 16];
  end

  // A channel acknowledged this cycle still shows valid; keep it out of
  // arbitration so it is not granted twice.
  assign w_pending = ch_req_valid & ~ch_req_ready_q;
  assign w_issue   = (state_q == ISSUE) && req_tready;
  assign w_retire  = resp_tvalid && resp_tready && (resp_tdata[63:48] != 16'd0);

  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_scan      = '0;
    // Scan farthest-to-nearest so the nearest pending index after last_grant wins.
    for (int k = CH_NUM; k >= 1; k--) begin
      w_scan = C_IDX_W'((int'(last_grant_q) + k) % CH_NUM);
      if (w_pending[w_scan]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_scan;
      end
    end
    w_win_burst = w_burst[w_win_idx];
    w_win_sof   = ch_req_sof[w_win_idx];
    w_win_eof   = ch_req_eof[w_win_idx];
  end

`ifdef CC_INGR_SCHED_ERR_EN
  assign w_bad_zero = (w_win_burst == 16'd0);
  assign w_bad_big  = (w_win_burst > MAX_BURST);
  assign w_unused   = ^resp_tdata[47:0];
`else
  assign w_bad_zero = 1'b0;
  assign w_bad_big  = 1'b0;
  assign w_unused   = ^{resp_tdata[47:0], MAX_BURST};
`endif
  assign w_win_bad = w_bad_zero || w_bad_big;

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    req_tdata_d    = req_tdata_q;
    ch_req_ready_d = '0;
    outstanding_d  = outstanding_q;
    w_underflow    = 1'b0;
    w_take         = 1'b0;
    w_load         = 1'b0;

    if (w_issue && !w_retire) begin
      outstanding_d = outstanding_q + 8'd1;
    end else if (!w_issue && w_retire) begin
      if (outstanding_q == 8'd0) w_underflow = 1'b1;
      else                       outstanding_d = outstanding_q - 8'd1;
    end

    unique case (state_q)
      IDLE: begin
        // Rejected requests are consumed without needing credit.
        if (w_win_found) begin
          if (w_win_bad) begin
            w_take = 1'b1;
          end else if (outstanding_q < C_MAX_OUT) begin
            w_take  = 1'b1;
            w_load  = 1'b1;
            state_d = ISSUE;
          end else if (!w_retire) begin
            state_d = FULL;
          end
        end
      end
      ISSUE: begin
        if (w_issue) begin
          if (outstanding_d == C_MAX_OUT) begin
            state_d = FULL;
          end else if (w_win_found && !w_win_bad) begin
            w_take = 1'b1;
            w_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FULL: begin
        if (w_retire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (w_take) begin
      last_grant_d              = w_win_idx;
      ch_req_ready_d[w_win_idx] = 1'b1;
    end
    if (w_load) begin
      req_tdata_d = {w_win_burst, 14'd0, w_win_eof, w_win_sof, 16'd0, 16'(w_win_idx)};
    end

    sched_error_d = {1'b0, w_underflow,
                     w_take && !w_load && w_bad_big,
                     w_take && !w_load && w_bad_zero};
    sched_error_ap_vld_d = |sched_error_d;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q              <= IDLE;
      last_grant_q         <= C_IDX_W'(CH_NUM - 1);
      outstanding_q        <= 8'd0;
      req_tdata_q          <= 64'd0;
      ch_req_ready_q       <= '0;
      sched_error_q        <= 4'd0;
      sched_error_ap_vld_q <= 1'b0;
    end else begin
      state_q              <= state_d;
      last_grant_q         <= last_grant_d;
      outstanding_q        <= outstanding_d;
      req_tdata_q          <= req_tdata_d;
      ch_req_ready_q       <= ch_req_ready_d;
      sched_error_q        <= sched_error_d;
      sched_error_ap_vld_q <= sched_error_ap_vld_d;
    end
  end

  assign req_tvalid         = (state_q == ISSUE);
  assign req_tdata          = req_tdata_q;
  assign ch_req_ready       = ch_req_ready_q;
  assign outstanding        = outstanding_q;
  assign sched_error        = sched_error_q;
  assign sched_error_ap_vld = sched_error_ap_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_cc_ingr_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_cc_ingr_req_scheduler
// Brief    : Self-checking bench for cc_ingr_req_scheduler (CH_NUM=4,
//            MAX_OUTSTANDING=4). Honours CC_INGR_SCHED_ERR_EN when defined.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_cc_ingr_req_scheduler;

  localparam int CH   = 4;
  localparam int MAXO = 4;
  localparam int NVEC = 27;

  logic            ap_clk = 1'b0;
  logic            ap_rst;
  logic [CH-1:0]   ch_req_valid, ch_req_sof, ch_req_eof, ch_req_ready;
  logic [16*CH-1:0] ch_req_burst;
  logic            req_tvalid, req_tready;
  logic [63:0]     req_tdata;
  logic            resp_tvalid, resp_tready;
  logic [63:0]     resp_tdata;
  logic [7:0]      outstanding;
  logic [3:0]      sched_error;
  logic            sched_error_ap_vld;

  int              n_tests = 0;
  int              n_fail  = 0;
  int              req_left [CH];
  logic [63:0]     sb_q [$];

  typedef struct {
    logic [CH-1:0] add;
    logic          tready;
    logic          resp;
    logic [15:0]   resp_b;
    logic          exp_tv;
    logic [CH-1:0] exp_rdy;
    logic [7:0]    exp_out;
    logic [3:0]    exp_err;
  } vec_t;
  vec_t tbl [NVEC];

  cc_ingr_req_scheduler #(
    .CH_NUM          (CH),
    .MAX_OUTSTANDING (MAXO),
    .MAX_BURST       (16'd4096)
  ) dut (
    .ap_clk             (ap_clk),
    .ap_rst             (ap_rst),
    .ch_req_valid       (ch_req_valid),
    .ch_req_burst       (ch_req_burst),
    .ch_req_sof         (ch_req_sof),
    .ch_req_eof         (ch_req_eof),
    .ch_req_ready       (ch_req_ready),
    .req_tvalid         (req_tvalid),
    .req_tready         (req_tready),
    .req_tdata          (req_tdata),
    .resp_tvalid        (resp_tvalid),
    .resp_tready        (resp_tready),
    .resp_tdata         (resp_tdata),
    .outstanding        (outstanding),
    .sched_error        (sched_error),
    .sched_error_ap_vld (sched_error_ap_vld)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic vec_t mkv(input logic [CH-1:0] add, input logic tr, input logic rv,
                               input logic [15:0] rb, input logic tv, input logic [CH-1:0] rdy,
                               input logic [7:0] o, input logic [3:0] e);
    vec_t v;
    v.add = add; v.tready = tr; v.resp = rv; v.resp_b = rb;
    v.exp_tv = tv; v.exp_rdy = rdy; v.exp_out = o; v.exp_err = e;
    return v;
  endfunction

  function automatic logic [63:0] word(input logic [15:0] b, input int ch);
    return {b, 14'd0, ch_req_eof[ch], ch_req_sof[ch], 16'd0, ch[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic upd_valid();
    for (int i = 0; i < CH; i++) ch_req_valid[i] = (req_left[i] > 0);
  endtask

  // Each set bit queues one more request on that channel.
  task automatic add_req(input logic [CH-1:0] m, input logic push);
    for (int i = 0; i < CH; i++) begin
      if (m[i]) begin
        req_left[i]++;
        if (push) sb_q.push_back(word(ch_req_burst[16*i +: 16], i));
      end
    end
    upd_valid();
  endtask

  // Advance one cycle; requesters retire a request when they see ch_req_ready.
  task automatic tick();
    @(posedge ap_clk);
    #1;
    for (int i = 0; i < CH; i++)
      if (ch_req_ready[i] && req_left[i] > 0) req_left[i]--;
    upd_valid();
  endtask

  task automatic chk_tdata_front(input string nm);
    if (sb_q.size() == 0) chk({nm, "_sb_nonempty"}, 64'd0, 64'd1);
    else                  chk(nm, req_tdata, sb_q[0]);
  endtask

  always @(negedge ap_clk) begin
    if (!ap_rst && req_tvalid && req_tready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_req: got 0x%0h, expected no request", req_tdata);
      end else begin
        chk("req_tdata_handshake", req_tdata, sb_q.pop_front());
      end
    end
  end

  logic       e_tv;
  logic [3:0] e_err1, e_err2;
  logic       e_push;
  logic [7:0] e_out2, e_out3, e_out4, e_out5;

  initial begin
    ap_rst       = 1'b1;
    ch_req_valid = '0;
    ch_req_sof   = 4'b0101;
    ch_req_eof   = 4'b1010;
    ch_req_burst = {4{16'd16}};
    req_tready   = 1'b0;
    resp_tvalid  = 1'b0;
    resp_tready  = 1'b0;
    resp_tdata   = '0;
    for (int i = 0; i < CH; i++) req_left[i] = 0;

    tbl[0]  = mkv(4'b1111, 1, 0, 16'd0,  1, 4'b0001, 8'd0, 4'd0);
    tbl[1]  = mkv(4'b0001, 1, 0, 16'd0,  1, 4'b0010, 8'd1, 4'd0);
    tbl[2]  = mkv(4'b0000, 1, 0, 16'd0,  1, 4'b0100, 8'd2, 4'd0);
    tbl[3]  = mkv(4'b0000, 1, 0, 16'd0,  1, 4'b1000, 8'd3, 4'd0);
    tbl[4]  = mkv(4'b0000, 1, 0, 16'd0,  0, 4'b0000, 8'd4, 4'd0);
    tbl[5]  = mkv(4'b0000, 1, 0, 16'd0,  0, 4'b0000, 8'd4, 4'd0);
    tbl[6]  = mkv(4'b0000, 1, 1, 16'd16, 0, 4'b0000, 8'd3, 4'd0);
    tbl[7]  = mkv(4'b0000, 1, 0, 16'd0,  1, 4'b0001, 8'd3, 4'd0);
    tbl[8]  = mkv(4'b0000, 1, 0, 16'd0,  0, 4'b0000, 8'd4, 4'd0);
    tbl[9]  = mkv(4'b0000, 1, 1, 16'd16, 0, 4'b0000, 8'd3, 4'd0);
    tbl[10] = mkv(4'b0000, 1, 1, 16'd16, 0, 4'b0000, 8'd2, 4'd0);
    tbl[11] = mkv(4'b0000, 1, 1, 16'd16, 0, 4'b0000, 8'd1, 4'd0);
    tbl[12] = mkv(4'b0010, 1, 0, 16'd0,  1, 4'b0010, 8'd1, 4'd0);
    tbl[13] = mkv(4'b0000, 1, 1, 16'd16, 0, 4'b0000, 8'd1, 4'd0);
    tbl[14] = mkv(4'b1100, 0, 0, 16'd0,  1, 4'b0100, 8'd1, 4'd0);
    for (int r = 15; r < 20; r++)
      tbl[r] = mkv(4'b0000, 0, 0, 16'd0, 1, 4'b0000, 8'd1, 4'd0);
    tbl[20] = mkv(4'b0000, 1, 0, 16'd0,  1, 4'b1000, 8'd2, 4'd0);
    tbl[21] = mkv(4'b0000, 1, 0, 16'd0,  0, 4'b0000, 8'd3, 4'd0);
    tbl[22] = mkv(4'b0000, 1, 1, 16'd16, 0, 4'b0000, 8'd2, 4'd0);
    tbl[23] = mkv(4'b0000, 1, 1, 16'd16, 0, 4'b0000, 8'd1, 4'd0);
    tbl[24] = mkv(4'b0000, 1, 1, 16'd16, 0, 4'b0000, 8'd0, 4'd0);
    tbl[25] = mkv(4'b0000, 1, 1, 16'd8,  0, 4'b0000, 8'd0, 4'b0100);
    tbl[26] = mkv(4'b0000, 1, 1, 16'd0,  0, 4'b0000, 8'd0, 4'd0);

    repeat (3) tick();
    ap_rst = 1'b0;
    chk("rst_tvalid", req_tvalid, 0);
    chk("rst_tdata", req_tdata, 0);
    chk("rst_ready", ch_req_ready, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", sched_error, 0);
    chk("rst_ap_vld", sched_error_ap_vld, 0);

    for (int r = 0; r < NVEC; r++) begin
      add_req(tbl[r].add, 1'b1);
      req_tready  = tbl[r].tready;
      resp_tvalid = tbl[r].resp;
      resp_tready = tbl[r].resp;
      resp_tdata  = {tbl[r].resp_b, 48'h5A5A_0000_1234};
      tick();
      chk($sformatf("v%0d_tvalid", r), req_tvalid, tbl[r].exp_tv);
      chk($sformatf("v%0d_ready", r), ch_req_ready, tbl[r].exp_rdy);
      chk($sformatf("v%0d_outstanding", r), outstanding, tbl[r].exp_out);
      chk($sformatf("v%0d_err", r), sched_error, tbl[r].exp_err);
      chk($sformatf("v%0d_ap_vld", r), sched_error_ap_vld, |tbl[r].exp_err);
      if (tbl[r].exp_tv) chk_tdata_front($sformatf("v%0d_tdata", r));
    end
    resp_tvalid = 1'b0;
    resp_tready = 1'b0;
    resp_tdata  = '0;

    // Illegal bursts: ch1 too long, ch2 zero; ch3 exactly MAX_BURST is legal.
`ifdef CC_INGR_SCHED_ERR_EN
    e_tv = 1'b0; e_err1 = 4'b0010; e_err2 = 4'b0001; e_push = 1'b0;
    e_out2 = 8'd0; e_out3 = 8'd0; e_out4 = 8'd0; e_out5 = 8'd1;
`else
    e_tv = 1'b1; e_err1 = 4'b0000; e_err2 = 4'b0000; e_push = 1'b1;
    e_out2 = 8'd1; e_out3 = 8'd2; e_out4 = 8'd2; e_out5 = 8'd3;
`endif
    ch_req_burst = {16'd4096, 16'd0, 16'd4097, 16'd16};
    req_tready   = 1'b1;
    add_req(4'b0110, e_push);
    tick();
    chk("err1_ready", ch_req_ready, 4'b0010);
    chk("err1_err", sched_error, e_err1);
    chk("err1_ap_vld", sched_error_ap_vld, |e_err1);
    chk("err1_tvalid", req_tvalid, e_tv);
    tick();
    chk("err2_ready", ch_req_ready, 4'b0100);
    chk("err2_err", sched_error, e_err2);
    chk("err2_ap_vld", sched_error_ap_vld, |e_err2);
    chk("err2_tvalid", req_tvalid, e_tv);
    chk("err2_outstanding", outstanding, e_out2);
    tick();
    chk("err3_tvalid", req_tvalid, 0);
    chk("err3_err", sched_error, 0);
    chk("err3_outstanding", outstanding, e_out3);
    add_req(4'b1000, 1'b1);
    tick();
    chk("maxb_ready", ch_req_ready, 4'b1000);
    chk("maxb_tvalid", req_tvalid, 1);
    chk_tdata_front("maxb_tdata");
    chk("maxb_outstanding", outstanding, e_out4);
    tick();
    chk("maxb_done_tvalid", req_tvalid, 0);
    chk("maxb_done_outstanding", outstanding, e_out5);

    // Reset while a request is pending drops it without a handshake.
    req_tready = 1'b0;
    add_req(4'b0001, 1'b0);
    tick();
    chk("mid_ready", ch_req_ready, 4'b0001);
    chk("mid_tvalid", req_tvalid, 1);
    ap_rst = 1'b1;
    tick();
    chk("mid_rst_tvalid", req_tvalid, 0);
    chk("mid_rst_tdata", req_tdata, 0);
    chk("mid_rst_outstanding", outstanding, 0);
    ap_rst     = 1'b0;
    req_tready = 1'b1;
    add_req(4'b0001, 1'b1);
    tick();
    chk("rereq_ready", ch_req_ready, 4'b0001);
    chk("rereq_tvalid", req_tvalid, 1);
    chk_tdata_front("rereq_tdata");
    tick();
    chk("rereq_done_tvalid", req_tvalid, 0);
    chk("rereq_outstanding", outstanding, 1);
    chk("sb_drained", 64'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
